// File: rtl/hiscore_ram_sched_if.sv
// Hiscore bus bundle: hps_io ioctl side plus the shared work-RAM side port.
// master = hps_io / core side, slave = the scheduler.
interface hiscore_ram_sched_if;
   logic        ioctl_download;
   logic        ioctl_upload;
   logic        ioctl_wr;
   logic        ioctl_rd;
   logic [7:0]  ioctl_index;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        ram_own;
   logic [9:0]  ram_address;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   modport master (
      output ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd,
      output ioctl_index, ioctl_addr, ioctl_dout, ram_rdata,
      input  ioctl_din, ioctl_wait, ram_own, ram_address, ram_we, ram_wdata
   );

   modport slave (
      input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd,
      input  ioctl_index, ioctl_addr, ioctl_dout, ram_rdata,
      output ioctl_din, ioctl_wait, ram_own, ram_address, ram_we, ram_wdata
   );
endinterface

// File: rtl/hiscore_ram_sched.sv
// Hiscore RAM scheduler: queues download bytes in a small FIFO and commits them,
// and services upload reads, only while the core is in vertical blank.
module hiscore_ram_sched #(
   parameter int HS_INDEX   = 4,
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  vblank,
   hiscore_ram_sched_if.slave    bus
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [24:0] RAM_LIMIT = 25'(RAM_WORDS);
   localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] WAIT_LVL  = (AW+1)'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [9:0]    fifo_addr [FIFO_DEPTH];
   logic [7:0]    fifo_data [FIFO_DEPTH];
   logic          fifo_oor  [FIFO_DEPTH];
   logic          rd_pend, pend_nxt, rd_oor;
   logic [9:0]    rd_addr;
   logic          hs_sel, sel_wr, sel_rd;
   logic          fifo_empty, fifo_full, push, pop;

   assign hs_sel     = (bus.ioctl_index == 8'(HS_INDEX));
   assign sel_wr     = hs_sel & bus.ioctl_download & bus.ioctl_wr;
   assign sel_rd     = hs_sel & bus.ioctl_upload & bus.ioctl_rd;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_LVL);
   // A push into a full FIFO is dropped so stored entries stay intact.
   assign push       = sel_wr & ~fifo_full;
   // The head is popped on the edge that loads it into the registered RAM outputs.
   assign pop        = vblank & ~fifo_empty & ((state == IDLE) | (state == WRITE));

   // Next FIFO occupancy and read-pending flag, shared by the status registers.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
      pend_nxt = rd_pend;
      if (state == RD_DATA) pend_nxt = 1'b0;
      if (sel_rd && !rd_pend) pend_nxt = 1'b1;
   end

   // FIFO storage; contents need no reset, the pointers define validity.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.ioctl_addr[9:0];
         fifo_data[wr_ptr] <= bus.ioctl_dout;
         fifo_oor[wr_ptr]  <= (bus.ioctl_addr >= RAM_LIMIT);
      end
   end

   // FIFO pointers, pending upload read and the hps_io stall.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         rd_pend        <= 1'b0;
         rd_addr        <= '0;
         rd_oor         <= 1'b0;
         bus.ioctl_wait <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count_nxt;
         rd_pend <= pend_nxt;
         // hps_io is stalled while a read is open, so a second request cannot
         // disturb the latched address of the one in flight.
         if (sel_rd && !rd_pend) begin
            rd_addr <= bus.ioctl_addr[9:0];
            rd_oor  <= (bus.ioctl_addr >= RAM_LIMIT);
         end
         bus.ioctl_wait <= (count_nxt >= WAIT_LVL) | pend_nxt;
      end
   end

   // Access sequencer with registered RAM-port outputs; drain beats reads and
   // a started access always runs to completion regardless of vblank.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state           <= IDLE;
         bus.ram_own     <= 1'b0;
         bus.ram_address <= '0;
         bus.ram_we      <= 1'b0;
         bus.ram_wdata   <= '0;
         bus.ioctl_din   <= '0;
      end else begin
         case (state)
            IDLE, WRITE: begin
               if (pop) begin
                  state           <= WRITE;
                  bus.ram_own     <= 1'b1;
                  bus.ram_address <= fifo_addr[rd_ptr];
                  bus.ram_we      <= ~fifo_oor[rd_ptr];
                  bus.ram_wdata   <= fifo_data[rd_ptr];
               end else if (state == IDLE && rd_pend && vblank && fifo_empty) begin
                  state           <= RD_ADDR;
                  bus.ram_own     <= 1'b1;
                  bus.ram_address <= rd_addr;
                  bus.ram_we      <= 1'b0;
                  bus.ram_wdata   <= '0;
               end else begin
                  state           <= IDLE;
                  bus.ram_own     <= 1'b0;
                  bus.ram_address <= '0;
                  bus.ram_we      <= 1'b0;
                  bus.ram_wdata   <= '0;
               end
            end
            RD_ADDR: begin
               state <= RD_DATA;
            end
            RD_DATA: begin
               bus.ioctl_din   <= rd_oor ? 8'h00 : bus.ram_rdata;
               state           <= IDLE;
               bus.ram_own     <= 1'b0;
               bus.ram_address <= '0;
               bus.ram_we      <= 1'b0;
               bus.ram_wdata   <= '0;
            end
            default: begin
               state           <= IDLE;
               bus.ram_own     <= 1'b0;
               bus.ram_address <= '0;
               bus.ram_we      <= 1'b0;
               bus.ram_wdata   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hiscore_ram_sched.sv
// Directed bench for the hiscore RAM scheduler with a registered-read RAM model.
module tb_hiscore_ram_sched;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic vblank  = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   own_cnt = 0;

   typedef struct {
      logic [9:0] a;
      logic [7:0] d;
      int         c;
   } wr_t;
   wr_t wr_log[$];

   logic [7:0] ram_mem [1024];

   hiscore_ram_sched_if bus ();

   hiscore_ram_sched #(.HS_INDEX(4), .RAM_WORDS(1024), .FIFO_DEPTH(16)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .vblank  (vblank),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: write on edge, read data valid one cycle after the address.
   always @(posedge clk_sys) begin
      cyc <= cyc + 1;
      if (bus.ram_own && bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_address];
   end

   // Port monitor sampled mid-cycle.
   always @(negedge clk_sys) begin
      if (bus.ram_own) own_cnt = own_cnt + 1;
      if (bus.ram_own && bus.ram_we) wr_log.push_back('{bus.ram_address, bus.ram_wdata, cyc});
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic rd_req(input logic [24:0] a);
      bus.ioctl_addr = a;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
   endtask

   task automatic clear_mon();
      wr_log.delete();
      own_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ioctl_download = 1'b1;
      bus.ioctl_upload   = 1'b1;
      bus.ioctl_index    = 8'd4;
      bus.ioctl_rd       = 1'b1;
      bus.ioctl_addr     = 25'h3FF;
      tick();
      bus.ioctl_rd = 1'b0;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.ram_own, bus.ram_we, bus.ram_address, bus.ram_wdata} !== 20'h0) begin
         errors++;
         $display("FAIL reset_ram: own=%b we=%b addr=%h wdata=%h required all 0",
                  bus.ram_own, bus.ram_we, bus.ram_address, bus.ram_wdata);
      end
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.ioctl_din !== 8'h00) begin
         errors++;
         $display("FAIL reset_ioctl: wait=%b din=%h required 0/00", bus.ioctl_wait, bus.ioctl_din);
      end
      // A strobe seen only during reset must not leave a read pending.
      vblank = 1'b1;
      clear_mon();
      repeat (4) tick();
      checks++;
      if (own_cnt !== 0) begin
         errors++;
         $display("FAIL reset_no_access: own cycles=%0d required 0", own_cnt);
      end
      vblank = 1'b0;
   endtask

   task automatic test_basic_drain();
      logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
      clear_mon();
      for (int i = 0; i < 3; i++) push_byte(25'h010 + 25'(i), exp_d[i]);
      repeat (3) tick();
      checks++;
      if (wr_log.size() !== 0 || own_cnt !== 0) begin
         errors++;
         $display("FAIL drain_blanked: writes=%0d own=%0d required 0/0", wr_log.size(), own_cnt);
      end
      vblank = 1'b1;
      repeat (6) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 3 || own_cnt !== 3) begin
         errors++;
         $display("FAIL drain_count: writes=%0d own=%0d required 3/3", wr_log.size(), own_cnt);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_log[i].a !== 10'h010 + 10'(i) || wr_log[i].d !== exp_d[i] ||
                (i > 0 && wr_log[i].c !== wr_log[i-1].c + 1)) begin
               errors++;
               $display("FAIL drain_entry%0d: addr=%h data=%h cyc=%0d required %h/%h consecutive",
                        i, wr_log[i].a, wr_log[i].d, wr_log[i].c, 10'h010 + 10'(i), exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      clear_mon();
      for (int i = 0; i < 14; i++) push_byte(25'h100 + 25'(i), 8'h40 + 8'(i));
      checks++;
      if (bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL bp_wait14: wait=%b required 0", bus.ioctl_wait);
      end
      push_byte(25'h10E, 8'h4E);
      checks++;
      if (bus.ioctl_wait !== 1'b1) begin
         errors++;
         $display("FAIL bp_wait15: wait=%b required 1", bus.ioctl_wait);
      end
      vblank = 1'b1;
      tick();
      checks++;
      if (bus.ioctl_wait !== 1'b0 || bus.ram_we !== 1'b1) begin
         errors++;
         $display("FAIL bp_first_pop: wait=%b we=%b required 0/1", bus.ioctl_wait, bus.ram_we);
      end
      repeat (18) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 15) begin
         errors++;
         $display("FAIL bp_count: writes=%0d required 15", wr_log.size());
      end else begin
         for (int i = 0; i < 15; i++) begin
            checks++;
            if (wr_log[i].a !== 10'h100 + 10'(i) || wr_log[i].d !== 8'h40 + 8'(i)) begin
               errors++;
               $display("FAIL bp_entry%0d: addr=%h data=%h required %h/%h",
                        i, wr_log[i].a, wr_log[i].d, 10'h100 + 10'(i), 8'h40 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_overflow();
      clear_mon();
      for (int i = 0; i < 17; i++) push_byte(25'h200 + 25'(i), 8'h80 + 8'(i));
      checks++;
      if (bus.ioctl_wait !== 1'b1) begin
         errors++;
         $display("FAIL ovf_wait: wait=%b required 1", bus.ioctl_wait);
      end
      vblank = 1'b1;
      repeat (20) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 16) begin
         errors++;
         $display("FAIL ovf_count: writes=%0d required 16", wr_log.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (wr_log[i].a !== 10'h200 + 10'(i) || wr_log[i].d !== 8'h80 + 8'(i)) begin
               errors++;
               $display("FAIL ovf_entry%0d: addr=%h data=%h required %h/%h",
                        i, wr_log[i].a, wr_log[i].d, 10'h200 + 10'(i), 8'h80 + 8'(i));
            end
         end
      end
   endtask

   task automatic test_upload_read();
      vblank = 1'b1;
      rd_req(25'h3FF);
      checks++;
      if (bus.ioctl_wait !== 1'b1 || bus.ram_own !== 1'b0) begin
         errors++;
         $display("FAIL rd_strobe: wait=%b own=%b required 1/0", bus.ioctl_wait, bus.ram_own);
      end
      tick();
      checks++;
      if (bus.ram_own !== 1'b1 || bus.ram_address !== 10'h3FF || bus.ram_we !== 1'b0 ||
          bus.ioctl_wait !== 1'b1) begin
         errors++;
         $display("FAIL rd_addr: own=%b addr=%h we=%b wait=%b required 1/3ff/0/1",
                  bus.ram_own, bus.ram_address, bus.ram_we, bus.ioctl_wait);
      end
      tick();
      checks++;
      if (bus.ram_own !== 1'b1 || bus.ioctl_wait !== 1'b1) begin
         errors++;
         $display("FAIL rd_data: own=%b wait=%b required 1/1", bus.ram_own, bus.ioctl_wait);
      end
      tick();
      checks++;
      if (bus.ioctl_din !== 8'h5C || bus.ioctl_wait !== 1'b0 || bus.ram_own !== 1'b0 ||
          bus.ram_address !== 10'h0) begin
         errors++;
         $display("FAIL rd_done: din=%h wait=%b own=%b addr=%h required 5c/0/0/000",
                  bus.ioctl_din, bus.ioctl_wait, bus.ram_own, bus.ram_address);
      end
      vblank = 1'b0;
   endtask

   task automatic test_oor();
      clear_mon();
      rd_req(25'h400);
      repeat (5) tick();
      checks++;
      if (bus.ioctl_wait !== 1'b1 || own_cnt !== 0 || bus.ioctl_din !== 8'h5C) begin
         errors++;
         $display("FAIL oor_held: wait=%b own=%0d din=%h required 1/0/5c",
                  bus.ioctl_wait, own_cnt, bus.ioctl_din);
      end
      vblank = 1'b1;
      repeat (3) tick();
      checks++;
      if (bus.ioctl_din !== 8'h00 || bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL oor_read: din=%h wait=%b required 00/0", bus.ioctl_din, bus.ioctl_wait);
      end
      vblank = 1'b0;
      tick();
      clear_mon();
      push_byte(25'h400, 8'h77);
      vblank = 1'b1;
      repeat (3) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 0 || own_cnt !== 1) begin
         errors++;
         $display("FAIL oor_write: writes=%0d own=%0d required 0/1", wr_log.size(), own_cnt);
      end
   endtask

   task automatic test_priority();
      clear_mon();
      ram_mem[10'h020] = 8'h00;
      push_byte(25'h020, 8'hB1);
      push_byte(25'h021, 8'hB2);
      rd_req(25'h020);
      vblank = 1'b1;
      repeat (4) tick();
      checks++;
      if (wr_log.size() !== 2 || bus.ram_own !== 1'b1 || bus.ram_we !== 1'b0 ||
          bus.ram_address !== 10'h020) begin
         errors++;
         $display("FAIL prio_order: writes=%0d own=%b we=%b addr=%h required 2/1/0/020",
                  wr_log.size(), bus.ram_own, bus.ram_we, bus.ram_address);
      end
      vblank = 1'b0;
      tick();
      checks++;
      if (bus.ram_own !== 1'b1 || bus.ioctl_wait !== 1'b1) begin
         errors++;
         $display("FAIL prio_rd_data: own=%b wait=%b required 1/1", bus.ram_own, bus.ioctl_wait);
      end
      tick();
      checks++;
      if (bus.ioctl_din !== 8'hB1 || bus.ioctl_wait !== 1'b0 || bus.ram_own !== 1'b0) begin
         errors++;
         $display("FAIL prio_rd_done: din=%h wait=%b own=%b required b1/0/0",
                  bus.ioctl_din, bus.ioctl_wait, bus.ram_own);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 5; i++) push_byte(25'h030 + 25'(i), 8'hC0 + 8'(i));
      vblank = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (bus.ram_we !== 1'b0 || bus.ram_own !== 1'b0 || bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: we=%b own=%b wait=%b required 0/0/0",
                  bus.ram_we, bus.ram_own, bus.ioctl_wait);
      end
      clear_mon();
      repeat (6) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 0 || own_cnt !== 0) begin
         errors++;
         $display("FAIL rst_fifo_empty: writes=%0d own=%0d required 0/0", wr_log.size(), own_cnt);
      end
   endtask

   task automatic test_select();
      clear_mon();
      bus.ioctl_index = 8'd3;
      push_byte(25'h040, 8'hD0);
      rd_req(25'h040);
      bus.ioctl_index = 8'd4;
      bus.ioctl_download = 1'b0;
      push_byte(25'h041, 8'hD1);
      bus.ioctl_download = 1'b1;
      checks++;
      if (bus.ioctl_wait !== 1'b0) begin
         errors++;
         $display("FAIL sel_wait: wait=%b required 0", bus.ioctl_wait);
      end
      vblank = 1'b1;
      repeat (4) tick();
      vblank = 1'b0;
      checks++;
      if (wr_log.size() !== 0 || own_cnt !== 0) begin
         errors++;
         $display("FAIL sel_ignored: writes=%0d own=%0d required 0/0", wr_log.size(), own_cnt);
      end
   endtask

   initial begin
      foreach (ram_mem[i]) ram_mem[i] = 8'h00;
      ram_mem[10'h3FF]   = 8'h5C;
      bus.ram_rdata      = 8'h00;
      bus.ioctl_download = 1'b0;
      bus.ioctl_upload   = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_rd       = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = 8'h00;
      test_reset();
      test_basic_drain();
      test_back_pressure();
      test_overflow();
      test_upload_read();
      test_oor();
      test_priority();
      test_reset_mid_drain();
      test_select();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hiscore_ram_sched.md
Name: hiscore_ram_sched

Overview:
- Schedules all hiscore traffic to the game work-RAM port that is shared with the Galaxian core.
- Download bytes (hiscore restore) go through a small FIFO. They are committed to RAM only inside vertical blank.
- Upload reads (hiscore save) are also serviced only inside vertical blank, with a wait handshake back to hps_io.
- Sits between hps_io and the galaxian RAM side port, clocked on clk_sys (12 MHz).

Parameters:
- HS_INDEX, 4: ioctl_index value that selects hiscore traffic.
- RAM_WORDS, 1024: number of addressable RAM bytes. Addresses at or above this are out of range.
- FIFO_DEPTH, 16: depth of the download FIFO, in address/data entries. Must be a power of 2.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- vblank  in  1  core vertical blank. RAM port may only be driven while it is high.
- ioctl_download  in  1  HPS download active.
- ioctl_upload  in  1  HPS upload active.
- ioctl_wr  in  1  one-cycle download byte strobe.
- ioctl_rd  in  1  one-cycle upload byte request.
- ioctl_index  in  8  transfer index.
- ioctl_addr  in  25  transfer byte address.
- ioctl_dout  in  8  download data.
- ioctl_din  out  8  upload data.
- ioctl_wait  out  1  stalls hps_io.
- ram_own  out  1  block owns the RAM port; core side is muxed out.
- ram_address  out  10  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid 1 cycle after the address is presented.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE. A reset mid-transfer discards FIFO contents and any pending read, and drops ioctl_wait the next cycle.
- Selection: a strobe is hiscore traffic only when ioctl_index==HS_INDEX and the matching ioctl_download/ioctl_upload is high. Other strobes are ignored.
- FIFO push: on a selected ioctl_wr, push {ioctl_addr[9:0], ioctl_dout, oor}, where oor = (ioctl_addr >= RAM_WORDS).
  - A push when full is a protocol error. The entry is dropped, and the FIFO is not corrupted.
  - ioctl_wait = 1 while FIFO count >= FIFO_DEPTH-1, OR while an upload read is pending/in flight.
- States:
  - IDLE: if vblank and FIFO non-empty, go to WRITE. Else if a read is pending and vblank and FIFO empty, go to RD_ADDR.
  - WRITE: ram_own=1. Pop one entry. ram_we=1 unless the entry is oor (an oor entry is popped with no write). Next state: WRITE if vblank and FIFO still non-empty, else IDLE. Drain rate is 1 byte/cycle.
  - RD_ADDR: ram_own=1, ram_address=latched addr, ram_we=0. Go to RD_DATA.
  - RD_DATA: ram_own=1. Capture ram_rdata into ioctl_din (0x00 if oor). Clear pending, drop ioctl_wait next cycle, go to IDLE.
- Read request: a selected ioctl_rd latches the address and sets pending. ioctl_wait rises the cycle after ioctl_rd and stays high until the RD_DATA capture. ioctl_din holds its value until the next capture.
- Priority: FIFO drain strictly beats reads. A simultaneous ioctl_wr and ioctl_rd are both accepted (push plus latch).
- vblank edges:
  - vblank falling never aborts an access. A WRITE cycle in progress completes; an issued RD_ADDR always completes RD_DATA.
  - No new access starts while vblank is low.
- ram_own is 1 exactly in WRITE, RD_ADDR and RD_DATA. When ram_own=0, ram_address=0.
- FIFO pointers: log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop keeps count unchanged.
- When ioctl_download falls, already-queued entries still drain at the next vblank(s).

Test Plan:
- Basic drain: with vblank=0, push 3 bytes (addr 0x010..0x012 = A1,A2,A3) → no ram_we. Raise vblank → 3 consecutive ram_we cycles, addresses 0x010,0x011,0x012, data A1,A2,A3, ram_own high for exactly 3 cycles.
- Back-pressure: with vblank=0, push 15 bytes → ioctl_wait=1 once count=15. Raise vblank → wait drops after the first pop; all 15 written in order.
- Upload read: RAM[0x3FF]=5C, vblank=1, ioctl_rd at 0x3FF → ioctl_wait high the next cycle, RD_ADDR then RD_DATA, ioctl_din=5C, wait low 3 cycles after the strobe.
- Blanked read plus out-of-range: ioctl_rd at 0x400 with vblank=0 → wait held until vblank, then ioctl_din=00. Write to 0x400 → popped with no ram_we.
- Priority/boundary: 2 FIFO entries pending and a read pending, vblank rises → 2 writes first, then the read. vblank falls during RD_ADDR → RD_DATA still completes.
- Reset mid-drain: 5 entries queued, reset during the 2nd WRITE → next cycle ram_we=0, ram_own=0, FIFO empty, ioctl_wait=0; a later vblank produces no writes.
